sev_seg_ctrl: RTL

Parametrised multiplexed seven-segment controller for N digits. It decodes each digit as hex or letter, then scans the digits in time. Per-digit features: decimal point, blank and blink. Global features: leading-zero suppression and PWM brightness. A frame-synchronous input snapshot prevents tearing, and a ghost-guard cycle precedes each digit slot. It sits between the board-level register/debug logic and the anode/segment pins, and supersedes the fixed 4-digit driver.

---
 rtl/sev_seg_pkg.sv | 47 ++++
 rtl/display_decoder.sv | 78 +++++++
 rtl/sev_seg_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// -----------------------------------------------------------------------------
// sev_seg_pkg
//   Shared constants, types and helpers for the multiplexed seven-segment
//   controller (sev_seg_ctrl) and its segment decoder (display_decoder).
//
//   SEG_OFF    : all segments and decimal point dark (outputs are active-low)
//   DP_BIT     : position of the decimal point inside the {dp, g..a} byte
//   MAX_DIGITS : widest display the controller supports
//   digit_t    : one 4-bit digit code
//   lz_mask()  : leading-zero suppression mask over a MAX_DIGITS-wide image
// -----------------------------------------------------------------------------
package sev_seg_pkg;

  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam int unsigned DP_BIT     = 7;
  localparam int unsigned MAX_DIGITS = 8;

  typedef logic [3:0] digit_t;

  // Bit k of the result is set when digit k (k >= 1) is a leading zero, i.e.
  // every nibble from position k up to n_digits-1 is zero. Digit 0 is never
  // flagged so a value of zero still shows a single "0". Positions at or
  // above n_digits are ignored and return 0.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] data,
    input int unsigned             n_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    int unsigned           pos;
    mask     = '0;
    all_zero = 1'b1;
    // Walk from the most significant position downwards so all_zero holds
    // "everything above and including this digit is zero".
    for (int unsigned j = 0; j < MAX_DIGITS; j++) begin
      pos = MAX_DIGITS - 1 - j;
      if (pos < n_digits) begin
        all_zero = all_zero & (data[4*pos +: 4] == 4'd0);
        if (pos != 0) begin
          mask[pos] = all_zero;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_decoder.sv
// -----------------------------------------------------------------------------
// display_decoder
//   Combinational 4-bit code to seven-segment pattern, active-low, {dp, g..a}.
//   The decimal point bit is always returned dark; the caller merges its own
//   decimal point request.
//
//   Hex mode (ltr_i = 0): 0-9, A, b, C, d, E, F.
//   Letter mode (ltr_i = 1):
//     0:A 1:b 2:C 3:d 4:E 5:F 6:H 7:L 8:P 9:U A:n B:o C:r D:t E:y F:-
//
//   Ports
//     data_i : digit code
//     ltr_i  : 1 = letter table, 0 = hex table
//     sseg_o : {dp, g, f, e, d, c, b, a}, active-low
// -----------------------------------------------------------------------------
module display_decoder
  import sev_seg_pkg::*;
(
  input  digit_t     data_i,
  input  logic       ltr_i,
  output logic [7:0] sseg_o
);

  logic [6:0] seg_hex;
  logic [6:0] seg_ltr;

  always_comb begin
    seg_hex = 7'h7F;
    unique case (data_i)
      4'h0: seg_hex = 7'h40;
      4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;
      4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;
      4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;
      4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;
      4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;
      4'hF: seg_hex = 7'h0E;
      default: seg_hex = 7'h7F;
    endcase
  end

  always_comb begin
    seg_ltr = 7'h7F;
    unique case (data_i)
      4'h0: seg_ltr = 7'h08; // A
      4'h1: seg_ltr = 7'h03; // b
      4'h2: seg_ltr = 7'h46; // C
      4'h3: seg_ltr = 7'h21; // d
      4'h4: seg_ltr = 7'h06; // E
      4'h5: seg_ltr = 7'h0E; // F
      4'h6: seg_ltr = 7'h09; // H
      4'h7: seg_ltr = 7'h47; // L
      4'h8: seg_ltr = 7'h0C; // P
      4'h9: seg_ltr = 7'h41; // U
      4'hA: seg_ltr = 7'h2B; // n
      4'hB: seg_ltr = 7'h23; // o
      4'hC: seg_ltr = 7'h2F; // r
      4'hD: seg_ltr = 7'h07; // t
      4'hE: seg_ltr = 7'h11; // y
      4'hF: seg_ltr = 7'h3F; // -
      default: seg_ltr = 7'h7F;
    endcase
  end

  always_comb begin
    sseg_o         = SEG_OFF;
    sseg_o[6:0]    = ltr_i ? seg_ltr : seg_hex;
  end

endmodule

// File: rtl/sev_seg_ctrl.sv
// -----------------------------------------------------------------------------
// sev_seg_ctrl
//   Time-multiplexed seven-segment controller for N_DIGITS digits. Each digit
//   owns a slot of SLOT_CYCLES clocks; the first clock of every slot keeps all
//   anodes off to stop the previous digit's segments ghosting into the next.
//   Inputs are captured once per frame (one full scan) so a display never
//   shows half of an update. Brightness is a PWM inside each slot, blink uses
//   a frame-counted half period, leading zeros can be blanked in hex mode.
//
//   Parameters
//     N_DIGITS     : digits scanned (1..8)
//     SLOT_CYCLES  : clocks per digit slot, multiple of 2**BRIGHT_W
//     BRIGHT_W     : brightness control width
//     BLINK_FRAMES : frames per blink half period (>= 1)
//
//   Ports
//     clk, rst : clock, asynchronous active-high reset
//     ltr_i    : 1 = letter decoding, 0 = hex decoding
//     data_i   : digit codes, digit k in data_i[4k+3:4k], digit 0 rightmost
//     dp_i     : decimal point request per digit
//     blank_i  : force digit dark
//     blink_i  : digit blinks
//     lz_en_i  : leading-zero suppression (hex mode only)
//     bright_i : duty = (bright_i+1)/2**BRIGHT_W
//     an_o     : anode enables, active-low
//     sseg_o   : {dp, g..a}, active-low
//     frame_o  : one-cycle pulse while the freshly loaded snapshot is first held
// -----------------------------------------------------------------------------
module sev_seg_ctrl
  import sev_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 65536,
  parameter int unsigned BRIGHT_W     = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ltr_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic [N_DIGITS-1:0]   blink_i,
  input  logic                  lz_en_i,
  input  logic [BRIGHT_W-1:0]   bright_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [7:0]            sseg_o,
  output logic                  frame_o
);

  localparam int unsigned SUB_LEN = SLOT_CYCLES >> BRIGHT_W;
  localparam int unsigned SLOT_W  = (SLOT_CYCLES  > 1) ? $clog2(SLOT_CYCLES)  : 1;
  localparam int unsigned IDX_W   = (N_DIGITS     > 1) ? $clog2(N_DIGITS)     : 1;
  localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SUBP_W  = (SUB_LEN      > 1) ? $clog2(SUB_LEN)      : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [SUBP_W-1:0] SUBP_LAST = SUBP_W'(SUB_LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [SUBP_W-1:0]     sub_pos_q,  sub_pos_d;
  logic [BRIGHT_W-1:0]   sub_q,      sub_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  blink_on_q, blink_on_d;

  logic [4*N_DIGITS-1:0] snap_data_q,   snap_data_d;
  logic [N_DIGITS-1:0]   snap_dp_q,     snap_dp_d;
  logic [N_DIGITS-1:0]   snap_blank_q,  snap_blank_d;
  logic [N_DIGITS-1:0]   snap_blink_q,  snap_blink_d;
  logic                  snap_ltr_q,    snap_ltr_d;
  logic                  snap_lz_en_q,  snap_lz_en_d;
  logic [BRIGHT_W-1:0]   snap_bright_q, snap_bright_d;

  logic [N_DIGITS-1:0]   an_q,    an_d;
  logic [7:0]            sseg_q,  sseg_d;
  logic                  frame_q, frame_d;

  // ---------------------------------------------------------------------------
  // Scan counters, blink phase and frame snapshot
  // ---------------------------------------------------------------------------
  logic slot_wrap;
  logic idx_wrap;
  logic frame_start;

  always_comb begin
    slot_wrap   = (slot_cnt_q == SLOT_LAST);
    idx_wrap    = (idx_q == IDX_LAST);
    frame_start = slot_wrap & idx_wrap;

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;

    // sub_q is slot_cnt / SUB_LEN, kept as a running quotient so a slot length
    // that is not a power of two needs no divider.
    sub_pos_d = sub_pos_q;
    sub_d     = sub_q;
    if (slot_wrap) begin
      sub_pos_d = '0;
      sub_d     = '0;
    end else if (sub_pos_q == SUBP_LAST) begin
      sub_pos_d = '0;
      sub_d     = sub_q + 1'b1;
    end else begin
      sub_pos_d = sub_pos_q + 1'b1;
    end

    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    end

    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    snap_blank_d  = snap_blank_q;
    snap_blink_d  = snap_blink_q;
    snap_ltr_d    = snap_ltr_q;
    snap_lz_en_d  = snap_lz_en_q;
    snap_bright_d = snap_bright_q;
    if (frame_start) begin
      snap_data_d   = data_i;
      snap_dp_d     = dp_i;
      snap_blank_d  = blank_i;
      snap_blink_d  = blink_i;
      snap_ltr_d    = ltr_i;
      snap_lz_en_d  = lz_en_i;
      snap_bright_d = bright_i;
    end

    frame_d = frame_start;
  end

  // ---------------------------------------------------------------------------
  // Current digit selection and decode
  // ---------------------------------------------------------------------------
  logic [4*MAX_DIGITS-1:0] data_pad;
  logic [N_DIGITS-1:0]     lz_vec;
  digit_t                  cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_blink;
  logic                    cur_sup;
  logic [7:0]              dec_seg;

  always_comb begin
    data_pad                   = '0;
    data_pad[4*N_DIGITS-1:0]   = snap_data_q;
    lz_vec = N_DIGITS'(lz_mask(data_pad, N_DIGITS));
    if (!snap_lz_en_q || snap_ltr_q) begin
      lz_vec = '0;
    end

    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_sup   = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_code  = snap_data_q[4*k +: 4];
        cur_dp    = snap_dp_q[k];
        cur_blank = snap_blank_q[k];
        cur_blink = snap_blink_q[k];
        cur_sup   = lz_vec[k];
      end
    end
  end

  display_decoder u_decoder (
    .data_i (cur_code),
    .ltr_i  (snap_ltr_q),
    .sseg_o (dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Output stage: registered from the current counter state
  // ---------------------------------------------------------------------------
  logic dark;
  logic pwm_on;
  logic guard;

  always_comb begin
    dark   = cur_blank | cur_sup | (cur_blink & ~blink_on_q);
    pwm_on = (sub_q <= snap_bright_q);
    guard  = (slot_cnt_q == '0);

    an_d = '1;
    if (!dark && pwm_on && !guard) begin
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          an_d[k] = 1'b0;
        end
      end
    end

    if (dark) begin
      sseg_d = SEG_OFF;
    end else begin
      sseg_d         = dec_seg;
      // Active-low: the point lights if the decoder or the request lights it.
      sseg_d[DP_BIT] = dec_seg[DP_BIT] & ~cur_dp;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      sub_pos_q     <= '0;
      sub_q         <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      snap_blink_q  <= '0;
      snap_ltr_q    <= 1'b0;
      snap_lz_en_q  <= 1'b0;
      snap_bright_q <= '0;
      an_q          <= '1;
      sseg_q        <= SEG_OFF;
      frame_q       <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      sub_pos_q     <= sub_pos_d;
      sub_q         <= sub_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_on_q    <= blink_on_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      snap_blink_q  <= snap_blink_d;
      snap_ltr_q    <= snap_ltr_d;
      snap_lz_en_q  <= snap_lz_en_d;
      snap_bright_q <= snap_bright_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_q       <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign sseg_o  = sseg_q;
  assign frame_o = frame_q;

endmodule
